// File: rtl/div_radix_iter.sv
// Iterative restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Retires BPC quotient bits per cycle; special cases resolve in a single cycle.
module div_radix_iter #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned BPC       = 2,
  parameter bit          EARLY_OUT = 1'b1,
  parameter int unsigned TAG_W     = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic             i_word,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [TAG_W-1:0] o_tag
);

  localparam int unsigned HW    = WIDTH / 2;
  localparam int unsigned MAX_N = WIDTH / BPC;
  localparam int unsigned CNT_W = $clog2(MAX_N + 1);
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned SH_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH:0]   rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic             is_rem_q;
  logic             word_q;
  logic [TAG_W-1:0] tag_q;

  // W-form results are the low half sign-extended, for signed and unsigned ops alike.
  function automatic logic [WIDTH-1:0] wfix(input logic word, input logic [WIDTH-1:0] v);
    wfix = word ? {{HW{v[HW-1]}}, v[HW-1:0]} : v;
  endfunction

  function automatic logic [IDX_W-1:0] msb_idx(input logic [WIDTH-1:0] v);
    msb_idx = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (v[i]) msb_idx = IDX_W'(i);
    end
  endfunction

  // Request decode: effective operands, magnitudes, special cases, iteration count.
  logic             is_signed_c;
  logic             is_rem_c;
  logic             dvd_neg_c;
  logic             dvs_neg_c;
  logic             div_zero_c;
  logic             ovf_c;
  logic             dvd_zero_c;
  logic             special_c;
  logic [WIDTH-1:0] dvd_eff_c;
  logic [WIDTH-1:0] dvs_eff_c;
  logic [WIDTH-1:0] dvd_mag_c;
  logic [WIDTH-1:0] dvs_mag_c;
  logic [WIDTH-1:0] min_eff_c;
  logic [WIDTH-1:0] spec_res_c;
  logic [WIDTH-1:0] a_init_c;
  logic [CNT_W-1:0] n_iter_c;
  logic [SH_W-1:0]  shamt_c;

  always_comb begin
    is_signed_c = ~i_op[0];
    is_rem_c    = i_op[1];
    if (i_word) begin
      dvd_eff_c = is_signed_c ? {{HW{i_dividend[HW-1]}}, i_dividend[HW-1:0]}
                              : {{HW{1'b0}}, i_dividend[HW-1:0]};
      dvs_eff_c = is_signed_c ? {{HW{i_divisor[HW-1]}}, i_divisor[HW-1:0]}
                              : {{HW{1'b0}}, i_divisor[HW-1:0]};
      min_eff_c = {{(HW + 1){1'b1}}, {(HW - 1){1'b0}}};
    end else begin
      dvd_eff_c = i_dividend;
      dvs_eff_c = i_divisor;
      min_eff_c = {1'b1, {(WIDTH - 1){1'b0}}};
    end
    dvd_neg_c  = is_signed_c & dvd_eff_c[WIDTH-1];
    dvs_neg_c  = is_signed_c & dvs_eff_c[WIDTH-1];
    dvd_mag_c  = dvd_neg_c ? -dvd_eff_c : dvd_eff_c;
    dvs_mag_c  = dvs_neg_c ? -dvs_eff_c : dvs_eff_c;
    div_zero_c = (dvs_eff_c == '0);
    ovf_c      = is_signed_c & (dvd_eff_c == min_eff_c) & (dvs_eff_c == '1);
    dvd_zero_c = EARLY_OUT & (dvd_mag_c == '0);
    special_c  = div_zero_c | ovf_c | dvd_zero_c;

    spec_res_c = '0;
    if (div_zero_c) begin
      spec_res_c = is_rem_c ? dvd_eff_c : '1;
    end else if (ovf_c) begin
      spec_res_c = is_rem_c ? '0 : dvd_eff_c;
    end

    if (EARLY_OUT) begin
      n_iter_c = CNT_W'(msb_idx(dvd_mag_c) / IDX_W'(BPC)) + CNT_W'(1);
    end else begin
      n_iter_c = i_word ? CNT_W'(HW / BPC) : CNT_W'(MAX_N);
    end
    // Align the first dividend bit to be consumed with the MSB of the shift register.
    shamt_c  = SH_W'(WIDTH - 32'(n_iter_c) * BPC);
    a_init_c = dvd_mag_c << shamt_c;
  end

  // BPC chained restoring stages, quotient bits MSB-first, then sign/W fixup.
  logic [WIDTH:0]   rem_n_c;
  logic [WIDTH:0]   trial_c;
  logic [WIDTH-1:0] a_n_c;
  logic [WIDTH-1:0] quo_n_c;
  logic [WIDTH-1:0] q_fix_c;
  logic [WIDTH-1:0] r_fix_c;
  logic [WIDTH-1:0] res_c;
  logic             ge_c;

  always_comb begin
    rem_n_c = rem_q;
    a_n_c   = a_q;
    quo_n_c = quo_q;
    trial_c = '0;
    ge_c    = 1'b0;
    for (int s = 0; s < int'(BPC); s++) begin
      trial_c = {rem_n_c[WIDTH-1:0], a_n_c[WIDTH-1]};
      ge_c    = rem_n_c[WIDTH] | (trial_c >= {1'b0, b_q});
      a_n_c   = {a_n_c[WIDTH-2:0], 1'b0};
      rem_n_c = ge_c ? (trial_c - {1'b0, b_q}) : trial_c;
      quo_n_c = {quo_n_c[WIDTH-2:0], ge_c};
    end
    q_fix_c = neg_q_q ? -quo_n_c : quo_n_c;
    r_fix_c = neg_r_q ? -rem_n_c[WIDTH-1:0] : rem_n_c[WIDTH-1:0];
    res_c   = wfix(word_q, is_rem_q ? r_fix_c : q_fix_c);
  end

  // Control FSM and registered datapath; flush overrides accept and response handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_tag    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      is_rem_q <= 1'b0;
      word_q   <= 1'b0;
      tag_q    <= '0;
    end else if (i_flush) begin
      state   <= S_IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            tag_q    <= i_tag;
            word_q   <= i_word;
            is_rem_q <= is_rem_c;
            neg_q_q  <= dvd_neg_c ^ dvs_neg_c;
            neg_r_q  <= dvd_neg_c;
            a_q      <= a_init_c;
            b_q      <= dvs_mag_c;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= n_iter_c;
            o_ready  <= 1'b0;
            if (special_c) begin
              state    <= S_DONE;
              o_valid  <= 1'b1;
              o_result <= wfix(i_word, spec_res_c);
              o_tag    <= i_tag;
            end else begin
              state <= S_ITER;
            end
          end
        end
        S_ITER: begin
          a_q   <= a_n_c;
          rem_q <= rem_n_c;
          quo_q <= quo_n_c;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state    <= S_DONE;
            o_valid  <= 1'b1;
            o_result <= res_c;
            o_tag    <= tag_q;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            state   <= S_IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix_iter.sv
// Scoreboarded bench for div_radix_iter: early-out instance plus a fixed-latency instance.
module tb_div_radix_iter;

  localparam int unsigned W  = 64;
  localparam int unsigned TW = 5;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam logic [W-1:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] MIN64 = 64'h8000_0000_0000_0000;

  typedef struct {
    logic [TW-1:0] tag;
    logic [W-1:0]  res;
    int            acc;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    d_op;
  logic          d_word;
  logic [W-1:0]  d_a;
  logic [W-1:0]  d_b;
  logic [TW-1:0] d_tag;

  logic          m_flush, m_valid, m_ready, m_o_ready, m_o_valid;
  logic [W-1:0]  m_result;
  logic [TW-1:0] m_tag_o;
  logic          fx_flush, fx_valid, fx_ready, fx_o_ready, fx_o_valid;
  logic [W-1:0]  fx_result;
  logic [TW-1:0] fx_tag_o;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb[$];
  exp_t e;
  logic seen  = 1'b0;

  div_radix_iter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(m_flush), .i_valid(m_valid), .o_ready(m_o_ready),
    .i_op(d_op), .i_word(d_word), .i_dividend(d_a), .i_divisor(d_b), .i_tag(d_tag),
    .o_valid(m_o_valid), .i_ready(m_ready), .o_result(m_result), .o_tag(m_tag_o)
  );

  div_radix_iter #(.EARLY_OUT(1'b0)) dut_fx (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(fx_flush), .i_valid(fx_valid), .o_ready(fx_o_ready),
    .i_op(d_op), .i_word(d_word), .i_dividend(d_a), .i_divisor(d_b), .i_tag(d_tag),
    .o_valid(fx_o_valid), .i_ready(fx_ready), .o_result(fx_result), .o_tag(fx_tag_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_div(input logic [1:0] op, input logic word,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    logic [31:0]  x32, y32, r32;
    logic [W-1:0] r;
    x32 = a[31:0];
    y32 = b[31:0];
    r32 = '0;
    r   = '0;
    if (word) begin
      if (y32 == 32'h0) r32 = op[1] ? x32 : 32'hFFFF_FFFF;
      else if (!op[0] && x32 == 32'h8000_0000 && y32 == 32'hFFFF_FFFF) r32 = op[1] ? 32'h0 : x32;
      else begin
        case (op)
          OP_DIV:  r32 = 32'($signed(x32) / $signed(y32));
          OP_DIVU: r32 = x32 / y32;
          OP_REM:  r32 = 32'($signed(x32) % $signed(y32));
          default: r32 = x32 % y32;
        endcase
      end
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == '0) r = op[1] ? a : ONES;
      else if (!op[0] && a == MIN64 && b == ONES) r = op[1] ? '0 : a;
      else begin
        case (op)
          OP_DIV:  r = 64'($signed(a) / $signed(b));
          OP_DIVU: r = a / b;
          OP_REM:  r = 64'($signed(a) % $signed(b));
          default: r = a % b;
        endcase
      end
    end
    return r;
  endfunction

  // Cycles from accept to o_valid for the early-out instance.
  function automatic int ref_lat(input logic [1:0] op, input logic word,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    logic         sgn;
    logic [W-1:0] x, y, mag, minv;
    int           top;
    sgn = !op[0];
    if (word) begin
      x    = sgn ? {{32{a[31]}}, a[31:0]} : {32'h0, a[31:0]};
      y    = sgn ? {{32{b[31]}}, b[31:0]} : {32'h0, b[31:0]};
      minv = 64'hFFFF_FFFF_8000_0000;
    end else begin
      x    = a;
      y    = b;
      minv = MIN64;
    end
    if (y == '0) return 1;
    if (sgn && x == minv && y == ONES) return 1;
    mag = (sgn && x[63]) ? -x : x;
    if (mag == '0) return 1;
    top = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) top = i;
    return top / 2 + 2;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 64'h1;
      2:       return ONES;
      3:       return MIN64;
      4:       return 64'h8000_0000;
      5:       return -64'($urandom_range(1, 300));
      6:       return 64'($urandom_range(0, 300));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Response monitor: compare result, tag and latency on the first cycle of each o_valid.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      if (m_o_valid && !seen) begin
        chk("sb_nonempty", 64'(sb.size() > 0), 64'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("result", m_result, e.res);
          chk("tag", 64'(m_tag_o), 64'(e.tag));
          chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
        end
      end
      seen = m_o_valid;
    end
  end

  task automatic issue(input logic [1:0] op, input logic word, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] tag,
                       input logic [W-1:0] exp_res, input int exp_lat);
    int n = 0;
    while (!m_o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!m_o_ready) chk("issue_ready_timeout", 64'(m_o_ready), 64'(1));
    d_op = op; d_word = word; d_a = a; d_b = b; d_tag = tag;
    m_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{tag, exp_res, cyc + 1, exp_lat});
    @(negedge clk);
    m_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    int n = 0;
    do begin
      m_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      n++;
    end while (!m_o_ready && n < 300);
    m_ready = 1'b1;
    if (!m_o_ready) chk("idle_timeout", 64'(m_o_ready), 64'(1));
  endtask

  task automatic run_fx(input string name, input logic [1:0] op, input logic word,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag,
                        input logic [W-1:0] exp_res, input int exp_lat);
    int n = 0;
    int acc;
    while (!fx_o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    d_op = op; d_word = word; d_a = a; d_b = b; d_tag = tag;
    fx_valid = 1'b1;
    @(posedge clk);
    acc = cyc + 1;
    @(negedge clk);
    fx_valid = 1'b0;
    n = 0;
    while (!fx_o_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, 64'(fx_o_valid), 64'(1));
    chk({name, "_result"}, fx_result, exp_res);
    chk({name, "_tag"}, 64'(fx_tag_o), 64'(tag));
    chk({name, "_latency"}, 64'(cyc - acc + 1), 64'(exp_lat));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] op;
    logic       word;
    logic [W-1:0] a, b;
    rst_n = 1'b0;
    m_flush = 1'b0; m_valid = 1'b0; m_ready = 1'b1;
    fx_flush = 1'b0; fx_valid = 1'b0; fx_ready = 1'b1;
    d_op = '0; d_word = 1'b0; d_a = '0; d_b = '0; d_tag = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(m_o_valid), 64'(0));
    chk("rst_result", m_result, '0);
    chk("rst_tag", 64'(m_tag_o), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(m_o_ready), 64'(1));

    // Fixed-latency instance: full Weff/BPC iterations.
    run_fx("fx_div_m7_2", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'h03, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_fx("fx_rem_m7_2", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'h04, ONES, 33);
    run_fx("fx_divuw", OP_DIVU, 1'b1, 64'hFFFF_FFFE, 64'd1, 5'h05, 64'hFFFF_FFFF_FFFF_FFFE, 17);
    run_fx("fx_divu_zero", OP_DIVU, 1'b0, 64'h64, 64'd0, 5'h06, ONES, 1);

    // Directed cases on the early-out instance.
    issue(OP_DIVU, 1'b0, 64'h64, 64'h0, 5'h01, ONES, 1);                          wait_idle(0);
    issue(OP_REMU, 1'b0, 64'h64, 64'h0, 5'h02, 64'h64, 1);                        wait_idle(0);
    issue(OP_DIV, 1'b0, MIN64, ONES, 5'h03, MIN64, 1);                            wait_idle(0);
    issue(OP_REM, 1'b0, MIN64, ONES, 5'h04, 64'h0, 1);                            wait_idle(0);
    issue(OP_DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'h05, 64'hFFFF_FFFF_8000_0000, 1); wait_idle(0);
    issue(OP_DIVU, 1'b1, 64'hFFFF_FFFE, 64'h1, 5'h06, 64'hFFFF_FFFF_FFFF_FFFE, 17); wait_idle(0);
    issue(OP_DIVU, 1'b0, 64'd5, 64'd2, 5'h07, 64'd2, 3);                          wait_idle(0);
    issue(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'h08, 64'hFFFF_FFFF_FFFF_FFFD, 3); wait_idle(0);
    issue(OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'h09, ONES, 3);          wait_idle(0);
    issue(OP_REM, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'h0A, 64'd1, 3);         wait_idle(0);
    issue(OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'h0B, 64'hFFFF_FFFF_FFFF_FFFB, 1); wait_idle(0);
    issue(OP_DIVU, 1'b0, 64'd0, 64'd9, 5'h0C, 64'd0, 1);                          wait_idle(0);
    issue(OP_DIVU, 1'b0, ONES, 64'd1, 5'h0D, ONES, 33);                           wait_idle(0);
    issue(OP_REMU, 1'b1, 64'hDEAD_BEEF_8000_0001, 64'h0, 5'h0E, 64'hFFFF_FFFF_8000_0001, 1); wait_idle(0);

    // Backpressure: response must hold while i_ready is low.
    m_ready = 1'b0;
    issue(OP_REMU, 1'b0, 64'd100, 64'd7, 5'h1A, 64'd2, 5);
    for (int n = 0; n < 50 && !m_o_valid; n++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(m_o_valid), 64'(1));
      chk("hold_result", m_result, 64'd2);
      chk("hold_tag", 64'(m_tag_o), 64'(5'h1A));
      chk("hold_ready", 64'(m_o_ready), 64'(0));
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", 64'(m_o_valid), 64'(0));
    chk("release_ready", 64'(m_o_ready), 64'(1));

    // Flush of a pending response beats the handshake; outputs keep their value.
    m_ready = 1'b0;
    issue(OP_DIVU, 1'b0, 64'd9, 64'd0, 5'h1B, ONES, 1);
    m_flush = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    m_flush = 1'b0;
    chk("flush_done_valid", 64'(m_o_valid), 64'(0));
    chk("flush_done_ready", 64'(m_o_ready), 64'(1));
    chk("flush_done_result", m_result, ONES);
    chk("flush_done_tag", 64'(m_tag_o), 64'(5'h1B));

    // Flush at T+10 of a long op; next request accepted at T+11.
    d_op = OP_DIVU; d_word = 1'b0; d_a = ONES; d_b = 64'd3; d_tag = 5'h1C;
    m_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_valid = 1'b0;
    repeat (9) @(negedge clk);
    m_flush = 1'b1;
    @(negedge clk);
    m_flush = 1'b0;
    chk("flush_iter_ready", 64'(m_o_ready), 64'(1));
    chk("flush_iter_valid", 64'(m_o_valid), 64'(0));
    chk("flush_iter_tag", 64'(m_tag_o), 64'(5'h1B));
    issue(OP_DIV, 1'b0, 64'd1000, 64'hFFFF_FFFF_FFFF_FFF9, 5'h1D, -64'd142, 6);
    wait_idle(0);

    // Asynchronous reset in the middle of an iteration.
    issue(OP_DIVU, 1'b0, ONES, 64'd3, 5'h1E, 64'h5555_5555_5555_5555, 33);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(m_o_valid), 64'(0));
    chk("midrst_ready", 64'(m_o_ready), 64'(1));
    chk("midrst_result", m_result, '0);
    chk("midrst_tag", 64'(m_tag_o), 64'(0));
    @(negedge clk);
    sb.delete();
    rst_n = 1'b1;
    @(negedge clk);
    issue(OP_REMU, 1'b0, 64'd1000, 64'd7, 5'h1F, 64'd6, 6);
    wait_idle(0);

    // Random mix with random response backpressure.
    for (int i = 0; i < 40; i++) begin
      op   = 2'($urandom_range(0, 3));
      word = 1'($urandom_range(0, 1));
      a    = pick();
      b    = pick();
      issue(op, word, a, b, TW'(i), ref_div(op, word, a, b), ref_lat(op, word, a, b));
      wait_idle(1);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
